// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the PLL reset controllers.
// Also provides the counter width helper used to size the sequencing timers.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_LOSS_CNT_W    = 8;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Clears to 0 on reset so the downstream logic starts from "not locked".
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies lock and gates the downstream system reset.
// Retries on lock timeout, re-sequences on lock loss, and latches FAIL when retries run out.
module pll_lock_supervisor
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int LOSS_CNT_W    = DEF_LOSS_CNT_W
) (
  input  logic                  refclk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  output logic                  pll_rst_o,
  output logic                  sys_rst_o,
  output logic                  ready_o,
  output logic                  lock_lost_o,
  output logic                  fail_o,
  output logic [7:0]            retry_cnt_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam int RST_W = cnt_w(RST_CYCLES);
  localparam int TMR_W = cnt_w(LOCK_TIMEOUT);
  localparam int STB_W = cnt_w(STABLE_CYCLES);
  localparam int RTY_W = cnt_w(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  pll_state_e            state_q;
  logic [RST_W-1:0]      rst_cnt_q;
  logic [TMR_W-1:0]      tmr_q;
  logic [STB_W-1:0]      stb_cnt_q;
  logic [RTY_W-1:0]      retry_q;
  logic [LOSS_CNT_W-1:0] loss_q;
  logic                  pll_rst_q;
  logic                  sys_rst_q;
  logic                  ready_q;
  logic                  lock_lost_q;
  logic                  fail_q;

  logic                  locked_s;
  logic                  timeout;
  logic [RTY_W-1:0]      retry_d;
  logic [LOSS_CNT_W-1:0] loss_d;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (refclk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );

  assign timeout = (tmr_q == TMR_LAST);
  assign retry_d = retry_q + RTY_W'(1);
  assign loss_d  = (&loss_q) ? loss_q : loss_q + LOSS_CNT_W'(1);

  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= PLL_RST;
      rst_cnt_q   <= '0;
      tmr_q       <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      unique case (state_q)
        PLL_RST: begin
          tmr_q     <= '0;
          stb_cnt_q <= '0;
          if (rst_cnt_q == RST_LAST) begin
            rst_cnt_q <= '0;
            pll_rst_q <= 1'b0;
            state_q   <= WAIT_LOCK;
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end

        // The lock timer spans both states so a chattering lock cannot
        // postpone the timeout indefinitely.
        WAIT_LOCK, STABLE: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (timeout) begin
            tmr_q     <= '0;
            stb_cnt_q <= '0;
            retry_q   <= retry_d;
            pll_rst_q <= 1'b1;
            if (retry_d == RTY_MAX) begin
              fail_q  <= 1'b1;
              state_q <= FAIL;
            end else begin
              state_q <= PLL_RST;
            end
          end else if (!locked_s) begin
            stb_cnt_q <= '0;
            state_q   <= WAIT_LOCK;
          end else if (state_q == WAIT_LOCK) begin
            stb_cnt_q <= '0;
            state_q   <= STABLE;
          end else if (stb_cnt_q == STB_LAST) begin
            stb_cnt_q <= '0;
            retry_q   <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= RUN;
          end else begin
            stb_cnt_q <= stb_cnt_q + STB_W'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
            loss_q      <= loss_d;
            state_q     <= PLL_RST;
          end
        end

        FAIL: begin
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
          fail_q    <= 1'b1;
        end

        default: begin
          rst_cnt_q <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
          state_q   <= PLL_RST;
        end
      endcase
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lock_lost_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = 8'(retry_q);
  assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues each expected output change
// with its edge number; a monitor pops and compares whenever the outputs change.
module tb_pll_lock_supervisor;

  typedef struct {
    int          cyc;
    logic [14:0] v;
  } ev_t;

  localparam logic [14:0] RESET_V = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic       fail;
  logic [7:0] retry_cnt;
  logic [1:0] loss_cnt;

  logic [14:0] obs;
  int          cyc;
  int          n_checks;
  int          n_err;
  ev_t         exp_q[$];

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(16),
    .MAX_RETRIES  (2),
    .SYNC_STAGES  (2),
    .LOSS_CNT_W   (2)
  ) dut (
    .refclk_i    (clk),
    .rst_i       (rst),
    .pll_locked_i(pll_locked),
    .pll_rst_o   (pll_rst),
    .sys_rst_o   (sys_rst),
    .ready_o     (ready),
    .lock_lost_o (lock_lost),
    .fail_o      (fail),
    .retry_cnt_o (retry_cnt),
    .loss_cnt_o  (loss_cnt)
  );

  assign obs = {pll_rst, sys_rst, ready, lock_lost, fail, retry_cnt, loss_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic pr, input logic sr, input logic rdy,
                           input logic ll, input logic fl, input logic [7:0] rc,
                           input logic [1:0] lc);
    ev_t e;
    e.cyc = c;
    e.v   = {pr, sr, rdy, ll, fl, rc, lc};
    exp_q.push_back(e);
  endtask

  // From RUN: drop lock; loss seen 3 edges later, PLL reset held 4 cycles.
  task automatic lose_lock(input logic [1:0] lc);
    int base;
    base = cyc;
    pll_locked = 1'b0;
    expect_ev(base + 3, 1, 1, 0, 1, 0, 8'd0, lc);
    expect_ev(base + 4, 1, 1, 0, 0, 0, 8'd0, lc);
    expect_ev(base + 7, 0, 1, 0, 0, 0, 8'd0, lc);
    step(7);
  endtask

  // From WAIT_LOCK: raise lock; first sampling edge is base+1, release on its 19th edge.
  task automatic relock_now(input logic [1:0] lc);
    int base;
    base = cyc;
    pll_locked = 1'b1;
    expect_ev(base + 19, 0, 0, 1, 0, 0, 8'd0, lc);
    step(19);
  endtask

  // Monitor
  initial begin
    ev_t         e;
    logic [14:0] prev;
    @(negedge clk);
    prev = obs;
    n_checks++;
    if (prev !== RESET_V) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", prev, RESET_V);
    end
    forever begin
      @(negedge clk);
      if (obs !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change: cyc=%0d got %h was %h", cyc, obs, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v !== obs) begin
            n_err++;
            $display("FAIL event: got %h at cyc %0d, want %h at cyc %0d", obs, cyc, e.v, e.cyc);
          end
        end
        prev = obs;
      end
    end
  end

  initial begin
    int base;
    n_checks   = 0;
    n_err      = 0;
    rst        = 1'b0;
    pll_locked = 1'b0;
    #1 rst = 1'b1;
    step(3);

    // 1: power-up, lock 10 cycles after pll_rst falls
    rst = 1'b0;
    base = cyc;
    expect_ev(base + 4, 0, 1, 0, 0, 0, 8'd0, 2'd0);
    step(4);
    step(10);
    relock_now(2'd0);
    step(5);

    // 4: lock loss in RUN, one timeout, relock clears retry_cnt
    lose_lock(2'd1);
    base = cyc;
    expect_ev(base + 100, 1, 1, 0, 0, 0, 8'd1, 2'd1);
    expect_ev(base + 104, 0, 1, 0, 0, 0, 8'd1, 2'd1);
    step(104);
    relock_now(2'd1);
    step(3);

    // 3: lock high 8, low 3, then high; must requalify from scratch
    lose_lock(2'd2);
    base = cyc;
    expect_ev(base + 30, 0, 0, 1, 0, 0, 8'd0, 2'd2);
    pll_locked = 1'b1;
    step(8);
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(19);
    step(2);

    // 5: loss counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      lose_lock(2'd3);
      relock_now(2'd3);
      step(2);
    end

    // 6: async reset mid-STABLE, then full restart with lock already high
    lose_lock(2'd3);
    pll_locked = 1'b1;
    step(5);
    #2;
    expect_ev(cyc, 1, 1, 0, 0, 0, 8'd0, 2'd0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    base = cyc;
    expect_ev(base + 4, 0, 1, 0, 0, 0, 8'd0, 2'd0);
    expect_ev(base + 21, 0, 0, 1, 0, 0, 8'd0, 2'd0);
    step(21);
    step(2);

    // 2: lock stays low, two timeouts -> FAIL; later lock ignored
    lose_lock(2'd1);
    base = cyc;
    expect_ev(base + 100, 1, 1, 0, 0, 0, 8'd1, 2'd1);
    expect_ev(base + 104, 0, 1, 0, 0, 0, 8'd1, 2'd1);
    expect_ev(base + 204, 1, 1, 0, 0, 1, 8'd2, 2'd1);
    step(204);
    step(4);
    pll_locked = 1'b1;
    step(40);
    step(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
